// File: rtl/mem_wb_pkg.sv
// Shared types and encodings for the memory-access / writeback stage.
package mem_wb_pkg;

  // Stage FSM: accept, issue request, wait for response, present writeback.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Writeback source select.
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_PC4  = 2'b01;
  localparam logic [1:0] WB_CSR  = 2'b10;
  localparam logic [1:0] WB_LOAD = 2'b11;

  // Access size from funct3[1:0]; funct3[2] selects zero-extension.
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;
  localparam logic [2:0] F3_LWU    = 3'b110;

  // Exception codes reported with out_exc.
  localparam logic [1:0] EXC_NONE           = 2'b00;
  localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'b01;
  localparam logic [1:0] EXC_STORE_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_ACCESS_FAULT   = 2'b11;

  // Mode of the shared align/lane unit.
  localparam logic ALIGN_LOAD  = 1'b0;
  localparam logic ALIGN_STORE = 1'b1;

  // True when the access cannot be performed: offset not a multiple of the
  // size, or a 64-bit-only access (double, lwu) on a 32-bit datapath.
  function automatic logic access_misaligned(input logic [2:0] funct3,
                                             input logic [2:0] offset,
                                             input logic       xlen64);
    logic mis;
    case (funct3[1:0])
      SZ_BYTE:   mis = 1'b0;
      SZ_HALF:   mis = offset[0];
      SZ_WORD:   mis = |offset[1:0];
      SZ_DOUBLE: mis = (!xlen64) || (|offset);
      default:   mis = 1'b1;
    endcase
    if ((funct3 == F3_LWU) && !xlen64) begin
      mis = 1'b1;
    end else begin
      mis = mis;
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// Byte-lane unit shared by loads and stores.
// Load mode : shift read data down by the byte offset, truncate to the access
//             size and sign/zero-extend to XLEN.
// Store mode: replicate the low size bytes across every lane and produce the
//             byte strobes for the addressed lanes.
module mem_wb_load_align
  import mem_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                          i_mode,
  input  logic [XLEN-1:0]               i_data,
  input  logic [$clog2(XLEN/8)-1:0]     i_offset,
  input  logic [2:0]                    i_funct3,
  output logic [XLEN-1:0]               o_data,
  output logic [XLEN/8-1:0]             o_wstrb
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] w_shift;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_ext;
  logic [XLEN-1:0] w_rep;
  logic            w_sign;
  logic [NB-1:0]   w_strb_base;
  logic [2:0]      w_lane_mask;

  assign w_shift = i_data >> {i_offset, 3'b000};

  // Per-size value mask, sign bit position, strobe pattern and lane wrap mask.
  always_comb begin
    w_mask      = '1;
    w_sign      = w_shift[XLEN-1];
    w_strb_base = '1;
    w_lane_mask = 3'b111;
    case (i_funct3[1:0])
      SZ_BYTE: begin
        w_mask      = XLEN'(64'h0000_0000_0000_00FF);
        w_sign      = w_shift[7];
        w_strb_base = NB'(8'h01);
        w_lane_mask = 3'b000;
      end
      SZ_HALF: begin
        w_mask      = XLEN'(64'h0000_0000_0000_FFFF);
        w_sign      = w_shift[15];
        w_strb_base = NB'(8'h03);
        w_lane_mask = 3'b001;
      end
      SZ_WORD: begin
        w_mask      = XLEN'(64'h0000_0000_FFFF_FFFF);
        w_sign      = w_shift[31];
        w_strb_base = NB'(8'h0F);
        w_lane_mask = 3'b011;
      end
      default: begin
        w_mask      = '1;
        w_sign      = w_shift[XLEN-1];
        w_strb_base = '1;
        w_lane_mask = 3'b111;
      end
    endcase
  end

  // Load extension: funct3[2] clear means sign-extend.
  always_comb begin
    if (w_sign && !i_funct3[2]) begin
      w_ext = (w_shift & w_mask) | ~w_mask;
    end else begin
      w_ext = w_shift & w_mask;
    end
  end

  // Store replication: lane i takes source byte (i mod size).
  always_comb begin
    w_rep = '0;
    for (int i = 0; i < NB; i++) begin
      w_rep[8*i +: 8] = i_data[8*((i & int'(w_lane_mask)) % NB) +: 8];
    end
  end

  // Mode select; loads never drive strobes.
  always_comb begin
    if (i_mode == ALIGN_STORE) begin
      o_data  = w_rep;
      o_wstrb = w_strb_base << i_offset;
    end else begin
      o_data  = w_ext;
      o_wstrb = '0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access and writeback stage. Holds one instruction, performs at most
// one bus transaction, and presents the writeback value downstream. All
// outputs are registered and zero in reset.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [XLEN-1:0]   in_alu_res,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_csr_out,
  input  logic [1:0]        in_wb_sel,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_rd_wen,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  input  logic              mem_resp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_rd_wen,
  output logic [XLEN-1:0]   out_wdata,
  output logic              out_exc,
  output logic [1:0]        out_exc_code
);

  localparam int   NB     = XLEN / 8;
  localparam int   OFF_W  = $clog2(NB);
  localparam logic XLEN64 = (XLEN == 64);

  state_e            r_state;
  state_e            w_state_nxt;

  // Fields needed after accept to build the writeback value.
  logic [ADDR_W-1:0] r_pc;
  logic [XLEN-1:0]   r_alu;
  logic [XLEN-1:0]   r_csr;
  logic [1:0]        r_wb_sel;
  logic [2:0]        r_funct3;
  logic [RD_W-1:0]   r_rd;
  logic              r_rd_wen;

  // Output registers.
  logic              r_in_ready;
  logic              r_req_valid;
  logic [ADDR_W-1:0] r_req_addr;
  logic              r_req_wen;
  logic [XLEN-1:0]   r_req_wdata;
  logic [NB-1:0]     r_req_wstrb;
  logic              r_out_valid;
  logic [RD_W-1:0]   r_out_rd;
  logic              r_out_rd_wen;
  logic [XLEN-1:0]   r_out_wdata;
  logic              r_out_exc;
  logic [1:0]        r_out_exc_code;

  logic              w_accept;
  logic              w_mem_op;
  logic              w_misal;
  logic [1:0]        w_acc_code;
  logic              w_resp_take;
  logic [ADDR_W-1:0] w_addr;

  logic              w_al_mode;
  logic [XLEN-1:0]   w_al_in;
  logic [OFF_W-1:0]  w_al_off;
  logic [2:0]        w_al_f3;
  logic [XLEN-1:0]   w_al_data;
  logic [NB-1:0]     w_al_strb;

  logic [1:0]        w_src_sel;
  logic [XLEN-1:0]   w_src_alu;
  logic [ADDR_W-1:0] w_src_pc;
  logic [XLEN-1:0]   w_src_csr;
  logic [XLEN-1:0]   w_src_load;
  logic [ADDR_W-1:0] w_pc4;
  logic [XLEN-1:0]   w_wb;

  // r_in_ready is only ever set while the FSM sits in IDLE.
  assign w_accept    = in_valid && r_in_ready;
  assign w_mem_op    = in_is_load || in_is_store;
  assign w_misal     = w_mem_op &&
                       access_misaligned(in_funct3, 3'(in_alu_res[OFF_W-1:0]), XLEN64);
  assign w_acc_code  = !w_misal   ? EXC_NONE :
                       in_is_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
  assign w_resp_take = (r_state == ST_WAIT) && mem_resp_valid;
  assign w_addr      = ADDR_W'(in_alu_res) & ~ADDR_W'(NB - 1);

  // Next-state logic; responses outside WAIT are ignored.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_mem_op && !w_misal) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The align unit builds store lanes at accept and aligns read data in WAIT.
  always_comb begin
    if (r_state == ST_WAIT) begin
      w_al_mode = ALIGN_LOAD;
      w_al_in   = mem_resp_data;
      w_al_off  = r_alu[OFF_W-1:0];
      w_al_f3   = r_funct3;
    end else begin
      w_al_mode = ALIGN_STORE;
      w_al_in   = in_rs2_data;
      w_al_off  = in_alu_res[OFF_W-1:0];
      w_al_f3   = in_funct3;
    end
  end

  mem_wb_load_align #(
    .XLEN (XLEN)
  ) u_align (
    .i_mode   (w_al_mode),
    .i_data   (w_al_in),
    .i_offset (w_al_off),
    .i_funct3 (w_al_f3),
    .o_data   (w_al_data),
    .o_wstrb  (w_al_strb)
  );

  // Writeback sources: latched fields on response, live inputs on accept.
  always_comb begin
    if (r_state == ST_WAIT) begin
      w_src_sel  = r_wb_sel;
      w_src_alu  = r_alu;
      w_src_pc   = r_pc;
      w_src_csr  = r_csr;
      w_src_load = w_al_data;
    end else begin
      w_src_sel  = in_wb_sel;
      w_src_alu  = in_alu_res;
      w_src_pc   = in_pc;
      w_src_csr  = in_csr_out;
      w_src_load = '0;
    end
  end

  assign w_pc4 = w_src_pc + ADDR_W'(4);

  // Writeback value mux.
  always_comb begin
    case (w_src_sel)
      WB_ALU:  w_wb = w_src_alu;
      WB_PC4:  w_wb = XLEN'(w_pc4);
      WB_CSR:  w_wb = w_src_csr;
      WB_LOAD: w_wb = w_src_load;
      default: w_wb = w_src_alu;
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      r_alu          <= '0;
      r_csr          <= '0;
      r_wb_sel       <= 2'b00;
      r_funct3       <= 3'b000;
      r_rd           <= '0;
      r_rd_wen       <= 1'b0;
      r_in_ready     <= 1'b0;
      r_req_valid    <= 1'b0;
      r_req_addr     <= '0;
      r_req_wen      <= 1'b0;
      r_req_wdata    <= '0;
      r_req_wstrb    <= '0;
      r_out_valid    <= 1'b0;
      r_out_rd       <= '0;
      r_out_rd_wen   <= 1'b0;
      r_out_wdata    <= '0;
      r_out_exc      <= 1'b0;
      r_out_exc_code <= EXC_NONE;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_IDLE);
      r_req_valid <= (w_state_nxt == ST_REQ);
      r_out_valid <= (w_state_nxt == ST_DONE);
      if (w_accept) begin
        r_pc        <= in_pc;
        r_alu       <= in_alu_res;
        r_csr       <= in_csr_out;
        r_wb_sel    <= in_wb_sel;
        r_funct3    <= in_funct3;
        r_rd        <= in_rd;
        r_rd_wen    <= in_rd_wen;
        r_req_addr  <= w_addr;
        r_req_wen   <= in_is_store;
        r_req_wdata <= in_is_store ? w_al_data : '0;
        r_req_wstrb <= in_is_store ? w_al_strb : '0;
      end
      if (w_accept && (w_state_nxt == ST_DONE)) begin
        r_out_rd       <= in_rd;
        r_out_wdata    <= w_wb;
        r_out_exc      <= w_misal;
        r_out_exc_code <= w_acc_code;
        r_out_rd_wen   <= in_rd_wen && !w_misal && (in_rd != '0);
      end else if (w_resp_take) begin
        r_out_rd       <= r_rd;
        r_out_wdata    <= w_wb;
        r_out_exc      <= mem_resp_err;
        r_out_exc_code <= mem_resp_err ? EXC_ACCESS_FAULT : EXC_NONE;
        r_out_rd_wen   <= r_rd_wen && !mem_resp_err && (r_rd != '0);
      end
    end
  end

  assign in_ready      = r_in_ready;
  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_wen   = r_req_wen;
  assign mem_req_wdata = r_req_wdata;
  assign mem_req_wstrb = r_req_wstrb;
  assign out_valid     = r_out_valid;
  assign out_rd        = r_out_rd;
  assign out_rd_wen    = r_out_rd_wen;
  assign out_wdata     = r_out_wdata;
  assign out_exc       = r_out_exc;
  assign out_exc_code  = r_out_exc_code;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage (XLEN=32): directed vectors push expected
// requests/writebacks into queues; monitors compare on every valid cycle.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_alu_res;
  logic [31:0] in_rs2_data;
  logic [31:0] in_csr_out;
  logic [1:0]  in_wb_sel;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_rd_wen;
  logic [31:0] out_wdata;
  logic        out_exc;
  logic [1:0]  out_exc_code;

  mem_wb_stage #(.XLEN(32), .ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_alu_res(in_alu_res), .in_rs2_data(in_rs2_data), .in_csr_out(in_csr_out),
    .in_wb_sel(in_wb_sel), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_wdata(out_wdata), .out_exc(out_exc),
    .out_exc_code(out_exc_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic        exc;
    logic [1:0]  code;
  } out_exp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_exp_t;

  out_exp_t out_q[$];
  req_exp_t req_q[$];
  out_exp_t mo_e;
  req_exp_t mr_e;
  int n_checks = 0;
  int n_pass = 0;
  int n_req_cycles = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic exp_out(input logic [4:0] rd, input logic wen, input logic [31:0] wd,
                         input logic chk, input logic exc, input logic [1:0] code);
    out_exp_t e;
    e.rd = rd; e.rd_wen = wen; e.wdata = wd; e.chk_wdata = chk; e.exc = exc; e.code = code;
    out_q.push_back(e);
  endtask

  task automatic exp_req(input logic [31:0] addr, input logic wen, input logic [31:0] wd,
                         input logic [3:0] strb);
    req_exp_t e;
    e.addr = addr; e.wen = wen; e.wdata = wd; e.wstrb = strb;
    req_q.push_back(e);
  endtask

  // Writeback monitor: compare every valid cycle (stability), pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (out_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out_valid: got out_valid=1 rd=%0d wdata=0x%0h, expected none", out_rd, out_wdata);
      end else begin
        mo_e = out_q[0];
        check("out_rd", 64'(out_rd), 64'(mo_e.rd));
        check("out_rd_wen", 64'(out_rd_wen), 64'(mo_e.rd_wen));
        check("out_exc", 64'(out_exc), 64'(mo_e.exc));
        check("out_exc_code", 64'(out_exc_code), 64'(mo_e.code));
        if (mo_e.chk_wdata) check("out_wdata", 64'(out_wdata), 64'(mo_e.wdata));
        if (out_ready) void'(out_q.pop_front());
      end
      check("in_ready_low_while_busy", 64'(in_ready), 64'(0));
    end
  end

  // Request monitor: fields must match and stay put until the handshake.
  always @(negedge clk) begin
    if (!rst && mem_req_valid) begin
      n_req_cycles++;
      if (req_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_mem_req: got addr=0x%0h, expected no request", mem_req_addr);
      end else begin
        mr_e = req_q[0];
        check("req_addr", 64'(mem_req_addr), 64'(mr_e.addr));
        check("req_wen", 64'(mem_req_wen), 64'(mr_e.wen));
        check("req_wdata", 64'(mem_req_wdata), 64'(mr_e.wdata));
        check("req_wstrb", 64'(mem_req_wstrb), 64'(mr_e.wstrb));
        if (mem_req_ready) void'(req_q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                      input logic [31:0] csr, input logic [1:0] sel, input logic ld,
                      input logic st, input logic [2:0] f3, input logic [4:0] rd,
                      input logic wen);
    int t;
    t = 0;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 after %0d cycles, expected 1", t);
    end else begin
      in_pc = pc; in_alu_res = alu; in_rs2_data = rs2; in_csr_out = csr;
      in_wb_sel = sel; in_is_load = ld; in_is_store = st; in_funct3 = f3;
      in_rd = rd; in_rd_wen = wen; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic mem_serve(input int hold, input int lat, input logic [31:0] data,
                           input logic err, input logic resp);
    int t;
    t = 0;
    while (!mem_req_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!mem_req_valid) begin
      n_checks++;
      $display("FAIL mem_req_timeout: got mem_req_valid=0, expected 1");
    end else begin
      repeat (hold) begin @(posedge clk); #1; end
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (resp) begin
        repeat (lat) begin @(posedge clk); #1; end
        mem_resp_valid = 1'b1; mem_resp_data = data; mem_resp_err = err;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0; mem_resp_data = 32'h0; mem_resp_err = 1'b0;
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((out_q.size() + req_q.size()) != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check(name, 64'(out_q.size() + req_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    int req_before;
    int ov_cnt;
    in_valid = 1'b0; in_pc = 32'h0; in_alu_res = 32'h0; in_rs2_data = 32'h0;
    in_csr_out = 32'h0; in_wb_sel = 2'b00; in_is_load = 1'b0; in_is_store = 1'b0;
    in_funct3 = 3'b000; in_rd = 5'd0; in_rd_wen = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    mem_resp_err = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_wdata", 64'(out_wdata), 64'(0));
    rst = 1'b0;

    // ALU op, 1-cycle latency, no memory traffic.
    req_before = n_req_cycles;
    exp_out(5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0, 2'b00);
    send(32'h100, 32'h1234, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 3'b010, 5'd5, 1'b1);
    check("alu_latency_out_valid", 64'(out_valid), 64'(1));
    drain("alu_drain");
    check("alu_no_mem_req", 64'(n_req_cycles - req_before), 64'(0));

    // lb sign-extended, then lbu.
    exp_req(32'h1000, 1'b0, 32'h0, 4'b0000);
    exp_out(5'd6, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 2'b00);
    send(32'h104, 32'h1003, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b000, 5'd6, 1'b1);
    mem_serve(0, 0, 32'h80FF_EE11, 1'b0, 1'b1);
    drain("lb_drain");
    exp_req(32'h1000, 1'b0, 32'h0, 4'b0000);
    exp_out(5'd6, 1'b1, 32'h0000_0080, 1'b1, 1'b0, 2'b00);
    send(32'h108, 32'h1003, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b100, 5'd6, 1'b1);
    mem_serve(0, 1, 32'h80FF_EE11, 1'b0, 1'b1);
    drain("lbu_drain");

    // sh with request backpressure of 3 cycles.
    exp_req(32'h2000, 1'b1, 32'h5678_5678, 4'b1100);
    exp_out(5'd0, 1'b0, 32'h0000_2002, 1'b1, 1'b0, 2'b00);
    send(32'h10C, 32'h2002, 32'hABCD_5678, 32'h0, 2'b00, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0);
    mem_serve(3, 0, 32'h0, 1'b0, 1'b1);
    drain("sh_drain");

    // Misaligned lw: no request, load-misaligned exception.
    req_before = n_req_cycles;
    exp_out(5'd7, 1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
    send(32'h110, 32'h3001, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b010, 5'd7, 1'b1);
    drain("mis_lw_drain");
    check("mis_lw_no_mem_req", 64'(n_req_cycles - req_before), 64'(0));

    // pc+4 with 4 cycles of output backpressure.
    out_ready = 1'b0;
    exp_out(5'd3, 1'b1, 32'h0000_1000, 1'b1, 1'b0, 2'b00);
    send(32'h0FFC, 32'h0, 32'h0, 32'h0, 2'b01, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    check("bp_out_valid_held", 64'(out_valid), 64'(1));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    drain("bp_drain");

    // CSR select.
    exp_out(5'd4, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b00);
    send(32'h114, 32'h55, 32'h0, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, 3'b000, 5'd4, 1'b1);
    drain("csr_drain");

    // Load with bus error.
    exp_req(32'h5000, 1'b0, 32'h0, 4'b0000);
    exp_out(5'd9, 1'b0, 32'h0, 1'b0, 1'b1, 2'b11);
    send(32'h118, 32'h5000, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1);
    mem_serve(1, 2, 32'h1111_2222, 1'b1, 1'b1);
    drain("err_drain");

    // lh sign-extended from upper half.
    exp_req(32'h6000, 1'b0, 32'h0, 4'b0000);
    exp_out(5'd8, 1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 2'b00);
    send(32'h11C, 32'h6002, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b001, 5'd8, 1'b1);
    mem_serve(0, 0, 32'h8001_7FFF, 1'b0, 1'b1);
    drain("lh_drain");

    // Aligned lw with 2-cycle response latency.
    exp_req(32'h7004, 1'b0, 32'h0, 4'b0000);
    exp_out(5'd10, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 2'b00);
    send(32'h120, 32'h7004, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1);
    mem_serve(0, 2, 32'h1234_5678, 1'b0, 1'b1);
    drain("lw_drain");

    // sb at offset 1.
    exp_req(32'h8000, 1'b1, 32'hA5A5_A5A5, 4'b0010);
    exp_out(5'd0, 1'b0, 32'h0000_8001, 1'b1, 1'b0, 2'b00);
    send(32'h124, 32'h8001, 32'h0000_00A5, 32'h0, 2'b00, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0);
    mem_serve(0, 0, 32'h0, 1'b0, 1'b1);
    drain("sb_drain");

    // Misaligned sw; ld on a 32-bit datapath; ALU write to x0.
    exp_out(5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 2'b10);
    send(32'h128, 32'h9002, 32'h1, 32'h0, 2'b00, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0);
    drain("mis_sw_drain");
    exp_out(5'd11, 1'b0, 32'h0, 1'b0, 1'b1, 2'b01);
    send(32'h12C, 32'hA000, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b011, 5'd11, 1'b1);
    drain("ld32_drain");
    exp_out(5'd0, 1'b0, 32'h0000_0077, 1'b1, 1'b0, 2'b00);
    send(32'h130, 32'h77, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 3'b000, 5'd0, 1'b1);
    drain("x0_drain");

    // Reset during WAIT, then a late response must be ignored.
    exp_req(32'h4000, 1'b0, 32'h0, 4'b0000);
    send(32'h134, 32'h4000, 32'h0, 32'h0, 2'b11, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1);
    mem_serve(0, 0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'(0));
    check("mid_rst_mem_req_valid", 64'(mem_req_valid), 64'(0));
    check("mid_rst_mem_req_addr", 64'(mem_req_addr), 64'(0));
    check("mid_rst_mem_req_wstrb", 64'(mem_req_wstrb), 64'(0));
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_out_rd", 64'(out_rd), 64'(0));
    check("mid_rst_out_rd_wen", 64'(out_rd_wen), 64'(0));
    check("mid_rst_out_wdata", 64'(out_wdata), 64'(0));
    check("mid_rst_out_exc", 64'(out_exc), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    check("post_rst_idle_in_ready", 64'(in_ready), 64'(1));
    ov_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    check("post_rst_no_out_valid", 64'(ov_cnt), 64'(0));

    // Recovery after reset.
    @(posedge clk); #1;
    exp_out(5'd12, 1'b1, 32'h0000_ABCD, 1'b1, 1'b0, 2'b00);
    send(32'h200, 32'hABCD, 32'h0, 32'h0, 2'b00, 1'b0, 1'b0, 3'b000, 5'd12, 1'b1);
    drain("recover_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
